// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
//   Shared constants for the input PIO slice: Avalon register map and the
//   encodings of the EDGE_TYPE parameter.
//   No ports.
// ---------------------------------------------------------------------------
package gpio_pkg;

   // Register map (word addresses on the 2-bit slave address)
   localparam logic [1:0] GPIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] GPIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] GPIO_ADDR_EDGE = 2'd3;

   // Which debounced transitions set an EDGE_CAPTURE bit
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/gpio_edge_in_if.sv
// ---------------------------------------------------------------------------
// gpio_edge_in_if
//   Avalon-MM slave bus bundle for the input PIO.
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (WIDTH bits)
//   readdata   : read data, zero latency (WIDTH bits)
//   Modports: master (interconnect side), slave (PIO side).
// ---------------------------------------------------------------------------
interface gpio_edge_in_if #(
   parameter int unsigned WIDTH = 4
) ();
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
//   One input bit: two-flop synchroniser followed by a hold-time debouncer.
//   A new level is accepted once the synchronised input has differed from the
//   accepted level for DEBOUNCE_CYCLES consecutive cycles.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   pin_i    : raw asynchronous pin
//   stable_o : debounced level
//   accept_o : high in the cycle stable_o is about to toggle
// ---------------------------------------------------------------------------
module gpio_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic        IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_i,
   output logic stable_o,
   output logic accept_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= IDLE_LEVEL;
         sync2_q  <= IDLE_LEVEL;
         stable_q <= IDLE_LEVEL;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= pin_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Counter only runs while the synchronised level disagrees; any return to
   // the accepted level clears it, so a bounce restarts the hold time.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      accept_o = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            accept_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/gpio_edge_in.sv
// ---------------------------------------------------------------------------
// gpio_edge_in
//   Avalon-MM input PIO: synchronised, debounced inputs with per-bit edge
//   capture and a maskable level interrupt.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata); reads are combinational, writes posted
//   in_port : raw asynchronous input pins (WIDTH bits)
//   irq     : level interrupt, |(EDGE_CAPTURE & IRQ_MASK)
// ---------------------------------------------------------------------------
module gpio_edge_in
   import gpio_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter int unsigned      EDGE_TYPE       = EDGE_ANY,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   gpio_edge_in_if.slave        bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] edge_ev;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] clr;
   logic             wr;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      gpio_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL[g])
      ) u_deb (
         .clk      (clk),
         .reset_n  (reset_n),
         .pin_i    (in_port[g]),
         .stable_o (stable[g]),
         .accept_o (accept[g])
      );
   end

   // accept flags the toggle cycle, so the current stable value is the old
   // level: old 0 means a rising edge, old 1 a falling edge.
   always_comb begin
      edge_ev = accept;
      if (EDGE_TYPE == EDGE_RISE) begin
         edge_ev = accept & ~stable;
      end else if (EDGE_TYPE == EDGE_FALL) begin
         edge_ev = accept & stable;
      end
   end

   assign wr = bus.chipselect && !bus.write_n;

   // Clear applied before set so a same-cycle edge survives the W1C write.
   always_comb begin
      clr    = '0;
      mask_d = mask_q;
      if (wr && bus.address == GPIO_ADDR_EDGE) begin
         clr = bus.writedata;
      end
      if (wr && bus.address == GPIO_ADDR_MASK) begin
         mask_d = bus.writedata;
      end
      cap_d = (cap_q & ~clr) | edge_ev;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
         cap_q  <= '0;
      end else begin
         mask_q <= mask_d;
         cap_q  <= cap_d;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         GPIO_ADDR_DATA: bus.readdata = stable;
         GPIO_ADDR_MASK: bus.readdata = mask_q;
         GPIO_ADDR_EDGE: bus.readdata = cap_q;
         default:        bus.readdata = '0;
      endcase
   end

   assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_gpio_edge_in.sv
// ---------------------------------------------------------------------------
// tb_gpio_edge_in
//   Scoreboarded bench for gpio_edge_in (WIDTH=4, DEBOUNCE_CYCLES=4,
//   EDGE_TYPE=any, IDLE_LEVEL=4'hF). A reference model tracks the expected
//   register contents; every read pushes the expected readdata/irq and a
//   negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_gpio_edge_in;
   import gpio_pkg::*;

   localparam int unsigned W   = 4;
   localparam int unsigned DEB = 4;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] in_port;
   logic         irq;
   logic         chk_valid;

   int unsigned  n_tests;
   int unsigned  n_fail;

   gpio_edge_in_if #(.WIDTH(W)) bus ();

   gpio_edge_in #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DEB),
      .EDGE_TYPE       (EDGE_ANY),
      .IDLE_LEVEL      (4'hF)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // pin_hist[0] = pin sampled at the previous edge, pin_hist[1] = two edges
   // ago; the debouncer acts on the pin as it was two edges earlier.
   logic [W-1:0] pin_hist [2];
   int unsigned  run_len  [W];
   logic [W-1:0] m_stable, m_cap, m_mask;
   logic [W-1:0] m_ev, m_clr, m_seen;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pin_hist[0] = 4'hF;
         pin_hist[1] = 4'hF;
         m_stable    = 4'hF;
         m_cap       = '0;
         m_mask      = '0;
         for (int i = 0; i < W; i++) run_len[i] = 0;
      end else begin
         m_seen = pin_hist[1];
         m_ev   = '0;
         for (int i = 0; i < W; i++) begin
            if (m_seen[i] != m_stable[i]) begin
               run_len[i] = run_len[i] + 1;
               if (run_len[i] == DEB) begin
                  m_ev[i]     = 1'b1;
                  m_stable[i] = m_seen[i];
                  run_len[i]  = 0;
               end
            end else begin
               run_len[i] = 0;
            end
         end
         m_clr = '0;
         if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 2'd3) m_clr  = bus.writedata;
            if (bus.address == 2'd2) m_mask = bus.writedata;
         end
         // any-edge capture; an edge in the clearing cycle still sets the bit
         m_cap       = (m_cap & ~m_clr) | m_ev;
         pin_hist[1] = pin_hist[0];
         pin_hist[0] = in_port;
      end
   end

   function automatic logic [W-1:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return m_stable;
         2'd2:    return m_mask;
         2'd3:    return m_cap;
         default: return '0;
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_rd_q  [$];
   logic         exp_irq_q [$];
   string        name_q    [$];

   always @(negedge clk) begin
      if (chk_valid && bus.chipselect && bus.write_n) begin
         n_tests++;
         if (exp_rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: read seen with no expected entry");
         end else begin
            logic [W-1:0] e_rd;
            logic         e_irq;
            string        nm;
            e_rd  = exp_rd_q.pop_front();
            e_irq = exp_irq_q.pop_front();
            nm    = name_q.pop_front();
            if (bus.readdata !== e_rd || irq !== e_irq) begin
               n_fail++;
               $display("FAIL %s: readdata=%h irq=%b, expected readdata=%h irq=%b",
                        nm, bus.readdata, irq, e_rd, e_irq);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus_quiet();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      chk_valid      = 1'b0;
   endtask

   task automatic op_idle();
      @(posedge clk); #1;
      bus_quiet();
   endtask

   task automatic op_pins(input logic [W-1:0] p);
      @(posedge clk); #1;
      bus_quiet();
      in_port = p;
   endtask

   task automatic op_write(input logic [1:0] a, input logic [W-1:0] d);
      @(posedge clk); #1;
      chk_valid      = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
   endtask

   task automatic issue_read(input logic [1:0] a, input string nm);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      exp_rd_q.push_back(model_rd(a));
      exp_irq_q.push_back(|(m_cap & m_mask));
      name_q.push_back(nm);
      chk_valid      = 1'b1;
   endtask

   task automatic op_read(input logic [1:0] a, input string nm);
      @(posedge clk); #1;
      issue_read(a, nm);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      reset_n       = 1'b0;
      in_port       = 4'hF;
      bus.address   = '0;
      bus.writedata = '0;
      bus_quiet();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // 1: reset values, idle pins produce nothing
      op_read(2'd0, "reset_data");
      op_read(2'd2, "reset_mask");
      op_read(2'd3, "reset_edge");
      op_read(2'd1, "reserved_zero");
      repeat (20) op_idle();
      op_read(2'd3, "idle_no_edge");
      op_read(2'd0, "idle_data");

      // 2: bit0 falls and is held; DATA tracked every cycle to pin the latency
      op_pins(4'hE);
      for (int i = 0; i < 7; i++) op_read(2'd0, "debounce_latency");
      op_read(2'd3, "debounce_capture");
      op_write(2'd3, 4'hF);
      op_read(2'd3, "w1c_all");
      op_pins(4'hF);
      repeat (8) op_idle();
      op_read(2'd3, "rise_capture_any");
      op_write(2'd3, 4'hF);

      // 3: bit1 low for fewer cycles than the hold time
      op_pins(4'hD);
      op_idle();
      op_idle();
      op_pins(4'hF);
      repeat (10) op_idle();
      op_read(2'd0, "bounce_data");
      op_read(2'd3, "bounce_edge");

      // 4: irq timing, W1C and partial clear
      op_write(2'd2, 4'h1);
      op_read(2'd2, "mask_rd");
      op_pins(4'hE);
      for (int i = 0; i < 7; i++) op_read(2'd3, "irq_assert");
      op_write(2'd3, 4'h1);
      op_read(2'd3, "irq_clear");
      op_pins(4'hD);            // bit0 back high, bit1 low: both edges together
      repeat (8) op_idle();
      op_read(2'd3, "two_edges");
      op_write(2'd3, 4'h2);
      op_read(2'd3, "partial_clear");
      op_write(2'd2, 4'h0);
      op_read(2'd3, "mask_off_irq");
      op_write(2'd1, 4'h7);     // ignored
      op_write(2'd0, 4'h0);     // ignored
      op_read(2'd0, "ignored_writes");

      // 5: W1C of bit2 in the very cycle its edge event fires
      op_write(2'd3, 4'hF);
      op_write(2'd2, 4'h4);
      op_pins(4'h9);            // bit2 falls (bit1 already low)
      repeat (4) op_idle();
      op_write(2'd3, 4'h4);     // sampled at the edge that accepts bit2
      op_read(2'd3, "collision_set_wins");
      op_read(2'd0, "collision_data");

      // 6: async reset mid-count, then fresh acceptance from zero
      op_pins(4'hF);
      repeat (8) op_idle();
      op_write(2'd2, 4'hF);
      op_write(2'd3, 4'hF);
      op_pins(4'hE);
      repeat (4) op_idle();     // bit0 count now at 2
      #1 reset_n = 1'b0;
      #1 issue_read(2'd2, "async_reset_mask");
      op_read(2'd0, "in_reset_data");
      op_read(2'd3, "in_reset_edge");
      @(posedge clk); #1;
      bus_quiet();
      reset_n = 1'b1;
      for (int i = 0; i < 7; i++) op_read(2'd0, "post_reset_accept");
      op_read(2'd3, "post_reset_edge");

      // random phase: pin changes (including bounces), reads, mask/W1C writes
      for (int n = 0; n < 600; n++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 35) begin
            logic [W-1:0] p;
            p = in_port;
            if ($urandom_range(0, 1) == 0) p = p ^ W'(1 << $urandom_range(0, W - 1));
            else                           p = W'($urandom);
            op_pins(p);
         end else if (r < 75) begin
            op_read(2'($urandom_range(0, 3)), "rand_read");
         end else if (r < 85) begin
            op_write(2'd2, W'($urandom));
         end else if (r < 95) begin
            op_write(2'd3, W'($urandom));
         end else if (r < 97) begin
            op_write(2'($urandom_range(0, 1)), W'($urandom));
         end else begin
            op_idle();
         end
      end

      op_idle();
      op_idle();
      n_tests++;
      if (exp_rd_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
